simd_decoder_pipe: RTL and testbench

- Parametrised, registered successor to the per-core instruction decoder.
- Accepts a fetched instruction over a valid/ready handshake, only while the core's SIMD state is DECODE.
- Splits the instruction into opcode, register fields and sign-extended immediate, and derives the control signals.
- Holds the result in a one-entry output stage with backpressure toward the register-read/ALU stage.

---
 rtl/simd_decoder_pipe.sv | 165 ++++++++++++++++
 tb/tb_simd_decoder_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/simd_decoder_pipe.sv
// Registered instruction decoder with a one-entry valid/ready output stage.
// Optional performance counters are enabled with the DECODER_PERF_EN macro.
module simd_decoder_pipe #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int REG_ADDR_WIDTH    = 4,
  parameter int IMM_WIDTH         = 16,
  parameter int DATA_WIDTH        = 32,
  parameter logic [2:0] DECODE_STATE = 3'd2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         flush,
  input  logic [2:0]                   simd_state,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   opcode,
  output logic [REG_ADDR_WIDTH-1:0]    rd,
  output logic [REG_ADDR_WIDTH-1:0]    rn,
  output logic [REG_ADDR_WIDTH-1:0]    rm,
  output logic [DATA_WIDTH-1:0]        imm,
  output logic [2:0]                   alu_op,
  output logic                         reg_write,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic                         mem_to_reg,
  output logic                         imm_sel,
  output logic                         branch,
  output logic                         ret,
  output logic                         illegal
`ifdef DECODER_PERF_EN
  ,
  output logic [31:0]                  decode_count,
  output logic [15:0]                  illegal_count
`endif
);

  localparam int IW = INSTRUCTION_WIDTH;
  localparam int R  = REG_ADDR_WIDTH;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_MUL  = 3'd3;
  localparam logic [2:0] ALU_DIV  = 3'd4;
  localparam logic [2:0] ALU_CMP  = 3'd5;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, state_next;
  logic   accept;

  logic [3:0]            dec_opcode;
  logic [2:0]            dec_alu_op;
  logic                  dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg;
  logic                  dec_imm_sel, dec_branch, dec_ret, dec_illegal;
  logic [DATA_WIDTH-1:0] dec_imm;

  assign out_valid = (state == FULL);
  assign in_ready  = enable && (simd_state == DECODE_STATE) && !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_next;
  end

  // Flush wins; a FULL stage refills on accept or empties once drained.
  always_comb begin
    state_next = state;
    if (flush)
      state_next = EMPTY;
    else if (accept)
      state_next = FULL;
    else if (state == FULL && out_ready)
      state_next = EMPTY;
  end

  assign dec_opcode = instruction[IW-1 -: 4];
  assign dec_imm    = DATA_WIDTH'($signed(instruction[IMM_WIDTH-1:0]));

  always_comb begin
    dec_alu_op     = ALU_PASS;
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_imm_sel    = 1'b0;
    dec_branch     = 1'b0;
    dec_ret        = 1'b0;
    dec_illegal    = 1'b0;
    case (dec_opcode)
      4'd0: dec_alu_op = ALU_PASS;
      4'd1: begin dec_reg_write = 1'b1; dec_alu_op = ALU_ADD; end
      4'd2: begin dec_reg_write = 1'b1; dec_alu_op = ALU_SUB; end
      4'd3: begin dec_reg_write = 1'b1; dec_alu_op = ALU_MUL; end
      4'd4: begin dec_reg_write = 1'b1; dec_alu_op = ALU_DIV; end
      4'd5: begin
        dec_reg_write  = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_imm_sel    = 1'b1;
        dec_alu_op     = ALU_ADD;
      end
      4'd6: begin dec_mem_write = 1'b1; dec_imm_sel = 1'b1; dec_alu_op = ALU_ADD; end
      4'd7: begin dec_reg_write = 1'b1; dec_imm_sel = 1'b1; end
      4'd8: dec_alu_op = ALU_CMP;
      4'd9: begin dec_branch = 1'b1; dec_imm_sel = 1'b1; end
      4'd15: dec_ret = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Bundle register only loads on accept, so a stalled bundle stays bit-stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode     <= '0;
      rd         <= '0;
      rn         <= '0;
      rm         <= '0;
      imm        <= '0;
      alu_op     <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      imm_sel    <= 1'b0;
      branch     <= 1'b0;
      ret        <= 1'b0;
      illegal    <= 1'b0;
    end else if (accept) begin
      opcode     <= dec_opcode;
      rd         <= instruction[IW-5 -: R];
      rn         <= instruction[IW-5-R -: R];
      rm         <= instruction[IW-5-2*R -: R];
      imm        <= dec_imm;
      alu_op     <= dec_alu_op;
      reg_write  <= dec_reg_write;
      mem_read   <= dec_mem_read;
      mem_write  <= dec_mem_write;
      mem_to_reg <= dec_mem_to_reg;
      imm_sel    <= dec_imm_sel;
      branch     <= dec_branch;
      ret        <= dec_ret;
      illegal    <= dec_illegal;
    end
  end

`ifdef DECODER_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      decode_count  <= '0;
      illegal_count <= '0;
    end else if (accept) begin
      decode_count <= decode_count + 32'd1;
      if (dec_illegal && illegal_count != 16'hFFFF)
        illegal_count <= illegal_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simd_decoder_pipe.sv
// Self-checking bench for simd_decoder_pipe: behavioural model compared every
// cycle, plus directed literal checks that pin the model.
module tb_simd_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, flush, in_valid, out_ready;
  logic [2:0]  simd_state;
  logic        in_ready, out_valid;
  logic [31:0] instruction;
  logic [3:0]  opcode;
  logic [3:0]  rd, rn, rm;
  logic [31:0] imm;
  logic [2:0]  alu_op;
  logic        reg_write, mem_read, mem_write, mem_to_reg, imm_sel, branch, ret, illegal;
`ifdef DECODER_PERF_EN
  logic [31:0] decode_count;
  logic [15:0] illegal_count;
`endif

  int total = 0;
  int bad   = 0;

  simd_decoder_pipe dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .simd_state(simd_state),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .rd(rd), .rn(rn), .rm(rm), .imm(imm), .alu_op(alu_op),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .imm_sel(imm_sel), .branch(branch), .ret(ret),
    .illegal(illegal)
`ifdef DECODER_PERF_EN
    , .decode_count(decode_count), .illegal_count(illegal_count)
`endif
  );

  always #5 clk = ~clk;

  // Control vector {alu_op[2:0], reg_write, mem_read, mem_write, mem_to_reg, imm_sel, branch, ret, illegal}
  function automatic logic [10:0] ctrl_of(input logic [3:0] op);
    case (op)
      4'd0:  return 11'b000_0000_0000;
      4'd1:  return 11'b001_1000_0000;
      4'd2:  return 11'b010_1000_0000;
      4'd3:  return 11'b011_1000_0000;
      4'd4:  return 11'b100_1000_0000;
      4'd5:  return 11'b001_1101_1000;
      4'd6:  return 11'b001_0010_1000;
      4'd7:  return 11'b000_1000_1000;
      4'd8:  return 11'b101_0000_0000;
      4'd9:  return 11'b000_0000_1100;
      4'd15: return 11'b000_0000_0010;
      default: return 11'b000_0000_0001;
    endcase
  endfunction

  logic [10:0] dut_ctrl;
  assign dut_ctrl = {alu_op, reg_write, mem_read, mem_write, mem_to_reg, imm_sel, branch, ret, illegal};

  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  int unsigned m_dec = 0;
  int unsigned m_ill = 0;

  function automatic logic model_ready();
    return enable && (simd_state == 3'd2) && !flush && (!m_valid || out_ready);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 1'b0;
      m_dec   = 0;
      m_ill   = 0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (in_valid && model_ready()) begin
      m_valid = 1'b1;
      m_instr = instruction;
      m_dec   = m_dec + 1;
      if (ctrl_of(instruction[31:28])[0] && m_ill < 16'hFFFF) m_ill = m_ill + 1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      checkOutput("in_ready", 32'(in_ready), 32'(model_ready()));
      checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        checkOutput("opcode", 32'(opcode), m_instr >> 28);
        checkOutput("rd", 32'(rd), (m_instr >> 24) & 32'hF);
        checkOutput("rn", 32'(rn), (m_instr >> 20) & 32'hF);
        checkOutput("rm", 32'(rm), (m_instr >> 16) & 32'hF);
        checkOutput("imm", imm, 32'($signed(m_instr[15:0])));
        checkOutput("ctrl", 32'(dut_ctrl), 32'(ctrl_of(m_instr[31:28])));
      end
`ifdef DECODER_PERF_EN
      checkOutput("decode_count", decode_count, m_dec);
      checkOutput("illegal_count", 32'(illegal_count), m_ill);
`endif
    end
  end

  task automatic applyStimulus(input logic iv, input logic [31:0] instr, input logic [2:0] st,
                               input logic en, input logic fl, input logic ordy);
    in_valid    = iv;
    instruction = instr;
    simd_state  = st;
    enable      = en;
    flush       = fl;
    out_ready   = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int run;

  initial begin
    rst = 1'b0;
    applyStimulus(0, 32'h0, 3'd2, 1, 0, 1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_ctrl", 32'(dut_ctrl), 32'h0);
    checkOutput("reset_imm", imm, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // LDR decode with negative immediate
    applyStimulus(1, 32'h5312FFFC, 3'd2, 1, 0, 1);
    tick();
    checkOutput("ldr_valid", 32'(out_valid), 32'h1);
    checkOutput("ldr_opcode", 32'(opcode), 32'h5);
    checkOutput("ldr_rd", 32'(rd), 32'h3);
    checkOutput("ldr_rn", 32'(rn), 32'h1);
    checkOutput("ldr_rm", 32'(rm), 32'h2);
    checkOutput("ldr_imm", imm, 32'hFFFFFFFC);
    checkOutput("ldr_ctrl", 32'(dut_ctrl), 32'(11'b001_1101_1000));

    // Asynchronous reset while a bundle is held
    applyStimulus(0, 32'h0, 3'd2, 1, 0, 0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'h0);
    checkOutput("async_rst_opcode", 32'(opcode), 32'h0);
    checkOutput("async_rst_fields", {20'h0, rd, rn, rm}, 32'h0);
    checkOutput("async_rst_ctrl", 32'(dut_ctrl), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Backpressure hold, then back-to-back replacement
    applyStimulus(1, 32'h1ABC0007, 3'd2, 1, 0, 0);
    tick();
    applyStimulus(1, 32'h2456800A, 3'd2, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_in_ready", 32'(in_ready), 32'h0);
      tick();
      checkOutput("stall_opcode", 32'(opcode), 32'h1);
      checkOutput("stall_imm", imm, 32'h7);
    end
    applyStimulus(1, 32'h2456800A, 3'd2, 1, 0, 1);
    checkOutput("drain_in_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("b2b_valid", 32'(out_valid), 32'h1);
    checkOutput("b2b_opcode", 32'(opcode), 32'h2);
    checkOutput("b2b_imm", imm, 32'hFFFF800A);

    // Wrong state / disabled / flush
    applyStimulus(1, 32'h30000001, 3'd3, 1, 0, 1);
    checkOutput("bad_state_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("bad_state_valid", 32'(out_valid), 32'h0);
    applyStimulus(1, 32'h30000001, 3'd2, 0, 0, 1);
    checkOutput("disabled_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("disabled_valid", 32'(out_valid), 32'h0);
    applyStimulus(1, 32'h70000123, 3'd2, 1, 0, 0);
    tick();
    applyStimulus(1, 32'h10000000, 3'd2, 1, 1, 0);
    checkOutput("flush_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("flush_valid", 32'(out_valid), 32'h0);

    // Illegal opcode still delivered
    applyStimulus(1, 32'hC0000000, 3'd2, 1, 0, 1);
    tick();
    checkOutput("illegal_valid", 32'(out_valid), 32'h1);
    checkOutput("illegal_ctrl", 32'(dut_ctrl), 32'h1);
`ifdef DECODER_PERF_EN
    checkOutput("illegal_count_lit", 32'(illegal_count), 32'h1);
`endif

    // Ten back-to-back ADDs
    run = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'h10000000 | (i << 24) | i, 3'd2, 1, 0, 1);
      tick();
      if (out_valid && alu_op == 3'd1 && reg_write) run++;
    end
    checkOutput("add_run", run, 32'd10);
    applyStimulus(0, 32'h0, 3'd2, 1, 0, 1);
    tick();
    checkOutput("add_run_end", 32'(out_valid), 32'h0);

    // Opcode sweep with mixed fields and sporadic stalls
    for (int op = 0; op < 16; op++) begin
      applyStimulus(1, (op << 28) | (32'($urandom) & 32'h0FFFFFFF), 3'd2, 1, 0, (op % 3) != 1);
      tick();
    end
    applyStimulus(0, 32'h0, 3'd2, 1, 0, 1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
